// File: rtl/seq_detector_param_moore_if.sv
// Serial detector bus: clear/valid/data in, registered detect pulse and match count out.
interface seq_detector_param_moore_if #(
  parameter int CNT_W = 8
);
  logic             clr;
  logic             in_valid;
  logic             x;
  logic             y;
  logic [CNT_W-1:0] match_count;

  modport master (output clr, in_valid, x, input  y, match_count);
  modport slave  (input  clr, in_valid, x, output y, match_count);
endinterface

// File: rtl/seq_detector_param_moore.sv
// Parameterised Moore serial pattern detector with fill tracking and optional overlap.
// Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param_moore #(
  parameter int                  PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1000,
  parameter int                  OVERLAP = 1,
  parameter int                  CNT_W   = 8
) (
  input logic                      clk,
  input logic                      rst,
  seq_detector_param_moore_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_y;

  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_match;

  always_comb begin
    w_hist_nxt = {r_hist[PAT_LEN-2:0], bus.x};
    w_fill_nxt = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    // Fill must be full so an all-zero pattern cannot fire on the reset history.
    w_match    = (w_hist_nxt == PATTERN) && (w_fill_nxt == FILL_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (bus.clr) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (bus.in_valid) begin
      r_hist <= w_hist_nxt;
      if (w_match && (OVERLAP == 0))
        r_fill <= '0;
      else
        r_fill <= w_fill_nxt;
      r_y    <= w_match;
    end else begin
      r_y    <= 1'b0;
    end
  end

  assign bus.y = r_y;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (bus.clr) begin
      r_count <= '0;
    end else if (bus.in_valid && w_match && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.match_count = r_count;
`else
  assign bus.match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/seq_detector_param_moore.md
SEQ_DETECTOR_PARAM_MOORE -- requirements
Module: seq_detector_param_moore

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1000: bit string to detect; MSB is the earliest-received bit.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: match counter width; legal range 1..32.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port clr, input, 1: synchronous clear of detector state and counter.
REQ-008 Port in_valid, input, 1: qualifies x; x is sampled only when in_valid=1.
REQ-009 Port x, input, 1: serial data bit.
REQ-010 Port y, output, 1: registered Moore detect pulse.
REQ-011 Port match_count, output, CNT_W: number of detections since reset or clr.

Function
REQ-012 Internal state SHALL be a PAT_LEN-bit history register hist plus a fill counter fill in the range 0..PAT_LEN.
REQ-013 On an edge with in_valid=1 and clr=0: hist <= {hist[PAT_LEN-2:0], x}; fill <= min(fill+1, PAT_LEN).
REQ-014 A match SHALL occur on that edge when the next hist equals PATTERN and the next fill equals PAT_LEN.
REQ-015 y SHALL be 1 for exactly the clock cycle following the edge that sampled the final pattern bit, and 0 otherwise.
REQ-016 Latency: one clock from sampling the last bit to y=1; there is no combinational path from x to y.
REQ-017 On an edge with in_valid=0, hist, fill and match_count SHALL hold, and y SHALL be 0.
REQ-018 With OVERLAP=1, fill SHALL stay at PAT_LEN after a match, so a trailing suffix of the match can start the next match.
REQ-019 With OVERLAP=0, a match SHALL set fill to 0, so the next match needs PAT_LEN fresh valid bits.
REQ-020 Back-to-back matches on consecutive valid edges SHALL hold y high on consecutive cycles.
REQ-021 clr=1 SHALL set hist=0, fill=0, y=0 and match_count=0 at the edge, taking priority over in_valid.
REQ-022 Until PAT_LEN valid bits have been taken since reset or clr, y SHALL remain 0, even when PATTERN is all zeros.

Reset
REQ-023 rst=0 SHALL immediately force hist=0, fill=0, y=0 and match_count=0, independent of clk.
REQ-024 A pattern in progress SHALL be discarded when rst is asserted mid-sequence; detection restarts from an empty history after release.
REQ-025 The first sampling edge SHALL be the first rising clk edge after rst goes high.

Configuration
REQ-026 Macro SEQ_DET_COUNT_EN, when defined, SHALL compile in match_count.
- It increments by 1 on every match edge.
- It saturates at 2^CNT_W-1 and never wraps.
REQ-027 Without SEQ_DET_COUNT_EN, the match_count port SHALL remain present and be driven constantly to 0; no counter logic is generated.

Verification
REQ-028 Default parameters; after reset, valid x = 1,0,0,0,1,0,0,0 -> y=1 in the cycles after the 4th and 8th bits only; match_count=2 (macro on).
REQ-029 PATTERN=4'b1111; valid x = 1,1,1,1,1,1:
- OVERLAP=1 -> y=1 after bits 4, 5 and 6.
- OVERLAP=0 -> y=1 after bit 4 only.
REQ-030 Default parameters; x = 1,0,0,0 with in_valid=0 during the 2nd bit's cycle (bit presented a cycle later) -> y=1 only after the 4th valid bit; y=0 during the stalled cycle.
REQ-031 Default parameters; rst pulsed low for a half cycle after valid bits 1,0,0 -> y stays 0; a new 1,0,0,0 is needed to produce y=1.
REQ-032 CNT_W=2, macro on; 5 matches of 1000 -> match_count steps 1,2,3,3,3; clr=1 together with in_valid=1 -> match_count=0 and y=0 next cycle.
REQ-033 Macro undefined; run the REQ-028 stimulus -> y identical to REQ-028; match_count=0 throughout.
